procyon_debug_ctrl: RTL and testbench
=====================================

// Module: procyon_debug_ctrl
// PURPOSE
//  Board-level run/halt debug controller between the procyon core and the FPGA I/O.
//  Drives a clock enable (o_clk_en) to the core rather than gating the clock.
//  Halt policy is chosen at run time: free-run, single-step, N-retire or breakpoint.
//  Keeps a circular history of retired writes (rdst, data) for 7-seg/LED readout.
// PARAMETERS
//  OPTN_DATA_WIDTH   32  retire data width
//  OPTN_ADDR_WIDTH   32  redirect/breakpoint address width
//  OPTN_RAT_DEPTH    32  arch regs; RAT_IDX_WIDTH = $clog2(OPTN_RAT_DEPTH)
//  OPTN_HIST_DEPTH   8   history entries, power of 2, >=2; HIST_IDX_WIDTH = $clog2(depth)
//  OPTN_CNT_WIDTH    16  retire counter / step count width
//  OPTN_RESET_HALT   0   1: leave reset in HALT; 0: leave reset in RUN
// PORTS
//  clk              in   1               system clock (CLOCK_50 domain)
//  n_rst            in   1               reset, synchronous, active-low
//  i_mode           in   2               0 FREE, 1 STEP, 2 COUNT, 3 BREAK
//  i_step_count     in   CNT_WIDTH       retires per run burst in COUNT mode
//  i_key_pulse      in   1               1-cycle debounced key pulse: resume/halt
//  i_retire_en      in   1               core retire valid
//  i_retire_rdst    in   RAT_IDX_WIDTH   retiring dest reg
//  i_retire_data    in   DATA_WIDTH      retiring data
//  i_redirect       in   1               core redirect valid
//  i_redirect_addr  in   ADDR_WIDTH      redirect target
//  i_bp_addr        in   ADDR_WIDTH      breakpoint address (macro only)
//  i_hist_sel       in   HIST_IDX_WIDTH  history read index, 0 = newest
//  o_clk_en         out  1               core clock enable
//  o_halted         out  1               state == HALT
//  o_hist_valid     out  1               selected entry holds data
//  o_hist_rdst      out  RAT_IDX_WIDTH   selected entry rdst
//  o_hist_data      out  DATA_WIDTH      selected entry data
//  o_retire_count   out  CNT_WIDTH       total counted retires, wraps
// BEHAVIOUR
//  - FSM RUN/HALT. o_clk_en = (state==RUN), combinational from state flop; o_halted = ~o_clk_en.
//  - Reset: state = OPTN_RESET_HALT ? HALT : RUN; counters, history, valid bits,
//    o_hist_* = 0; remaining = max(i_step_count,1).
//  - Counted retire: i_retire_en & o_clk_en in the same cycle. Core inputs are ignored in HALT.
//  - Each counted retire: o_retire_count++ (wraps); history written at wr_ptr, wr_ptr++ (wraps);
//    valid count saturates at OPTN_HIST_DEPTH.
//  - RUN->HALT, next cycle, when any of:
//    i_key_pulse (manual halt, all modes);
//    STEP & counted retire;
//    COUNT & counted retire & remaining==1;
//    BREAK & o_clk_en & i_redirect & i_redirect_addr==i_bp_addr.
//    Key pulse coinciding with a halt condition gives a single HALT, not a resume.
//  - HALT->RUN on i_key_pulse; remaining reloaded with max(i_step_count,1) on that edge.
//  - COUNT: remaining decrements per counted retire while in RUN.
//  - i_mode changes take effect next cycle; remaining is not reloaded by a mode change.
//  - History read: registered, 1-cycle latency. Entry index = wr_ptr-1-i_hist_sel (mod depth).
//    o_hist_valid = i_hist_sel < valid count; when invalid, rdst/data read 0.
//  - Write and read of the same slot in one cycle returns the old contents.
//  - Reset mid-RUN or mid-HALT aborts everything; no partial state survives.
// CONFIGURATION
//  PROCYON_DEBUG_BREAKPOINT_EN
//    defined:   i_bp_addr and BREAK mode are active as above.
//    undefined: i_bp_addr port is absent; mode 3 behaves exactly as FREE.
// TESTING
//  1. RESET_HALT=0, mode FREE, 20 retires -> o_clk_en stays 1, o_retire_count=20,
//     hist_sel 0 returns the 20th retire.
//  2. Mode STEP, retire (r5,0xDEAD) -> halted next cycle, retire_en held 10 cycles while halted
//     -> count +1 only; key pulse -> exactly one more counted retire, then halt.
//  3. Mode COUNT, step_count=3, retire every cycle -> halt after the 3rd;
//     step_count=0 -> halt after the 1st.
//  4. 10 retires into a depth-8 history -> sel 0..7 valid = retires 10..3.
//     After reset plus 2 retires: sel 2 -> valid=0, data=0.
//  5. Macro on, BREAK, bp=0x100: redirects to 0x0FC then 0x100 -> halt only after the 0x100 redirect.
//     Macro off, mode 3 -> never halts on its own.
//  6. Key pulse coinciding with a STEP retire -> HALT. n_rst low during RUN -> all outputs reset next cycle.

Source files
------------

// File: rtl/procyon_debug_ctrl.sv
// procyon run/halt debug controller: clock-enable FSM, retire counter, retire history.
// Optional breakpoint halting is built when PROCYON_DEBUG_BREAKPOINT_EN is defined.
module procyon_debug_ctrl #(
    parameter int OPTN_DATA_WIDTH = 32,
    parameter int OPTN_ADDR_WIDTH = 32,
    parameter int OPTN_RAT_DEPTH  = 32,
    parameter int OPTN_HIST_DEPTH = 8,
    parameter int OPTN_CNT_WIDTH  = 16,
    parameter int OPTN_RESET_HALT = 0,
    localparam int RAT_IDX_WIDTH  = $clog2(OPTN_RAT_DEPTH),
    localparam int HIST_IDX_WIDTH = $clog2(OPTN_HIST_DEPTH)
) (
    input  logic                       clk,
    input  logic                       n_rst,
    input  logic [1:0]                 i_mode,
    input  logic [OPTN_CNT_WIDTH-1:0]  i_step_count,
    input  logic                       i_key_pulse,
    input  logic                       i_retire_en,
    input  logic [RAT_IDX_WIDTH-1:0]   i_retire_rdst,
    input  logic [OPTN_DATA_WIDTH-1:0] i_retire_data,
    input  logic                       i_redirect,
    input  logic [OPTN_ADDR_WIDTH-1:0] i_redirect_addr,
`ifdef PROCYON_DEBUG_BREAKPOINT_EN
    input  logic [OPTN_ADDR_WIDTH-1:0] i_bp_addr,
`endif
    input  logic [HIST_IDX_WIDTH-1:0]  i_hist_sel,
    output logic                       o_clk_en,
    output logic                       o_halted,
    output logic                       o_hist_valid,
    output logic [RAT_IDX_WIDTH-1:0]   o_hist_rdst,
    output logic [OPTN_DATA_WIDTH-1:0] o_hist_data,
    output logic [OPTN_CNT_WIDTH-1:0]  o_retire_count
);

    typedef enum logic [0:0] {
        RUN  = 1'b0,
        HALT = 1'b1
    } state_t;

    localparam logic [1:0] MODE_STEP  = 2'd1;
    localparam logic [1:0] MODE_COUNT = 2'd2;

    state_t                      state;
    logic [OPTN_CNT_WIDTH-1:0]   remaining;
    logic [OPTN_CNT_WIDTH-1:0]   load_val;
    logic [HIST_IDX_WIDTH-1:0]   wr_ptr;
    logic [HIST_IDX_WIDTH-1:0]   rd_idx;
    logic [HIST_IDX_WIDTH:0]     vcnt;
    logic [RAT_IDX_WIDTH-1:0]    hist_rdst [OPTN_HIST_DEPTH];
    logic [OPTN_DATA_WIDTH-1:0]  hist_data [OPTN_HIST_DEPTH];
    logic                        counted;
    logic                        bp_hit;
    logic                        halt_req;

    assign o_clk_en = (state == RUN);
    assign o_halted = ~o_clk_en;

    assign load_val = (i_step_count == '0) ? OPTN_CNT_WIDTH'(1) : i_step_count;
    assign counted  = i_retire_en & o_clk_en;

`ifdef PROCYON_DEBUG_BREAKPOINT_EN
    assign bp_hit = (i_mode == 2'd3) & i_redirect & (i_redirect_addr == i_bp_addr);
`else
    // Mode 3 degenerates to free-run; redirect info has no consumer.
    logic unused_redirect;
    assign unused_redirect = ^{i_redirect, i_redirect_addr};
    assign bp_hit = 1'b0;
`endif

    assign halt_req = i_key_pulse
                    | ((i_mode == MODE_STEP) & i_retire_en)
                    | ((i_mode == MODE_COUNT) & i_retire_en
                       & (remaining == OPTN_CNT_WIDTH'(1)))
                    | bp_hit;

    // Newest entry sits just behind the write pointer.
    assign rd_idx = wr_ptr - HIST_IDX_WIDTH'(1) - i_hist_sel;

    always_ff @(posedge clk) begin
        if (!n_rst) begin
            state          <= (OPTN_RESET_HALT != 0) ? HALT : RUN;
            remaining      <= load_val;
            o_retire_count <= '0;
            wr_ptr         <= '0;
            vcnt           <= '0;
            o_hist_valid   <= 1'b0;
            o_hist_rdst    <= '0;
            o_hist_data    <= '0;
            for (int i = 0; i < OPTN_HIST_DEPTH; i++) begin
                hist_rdst[i] <= '0;
                hist_data[i] <= '0;
            end
        end else begin
            unique case (state)
                RUN: begin
                    if (halt_req) state <= HALT;
                end
                HALT: begin
                    if (i_key_pulse) begin
                        state     <= RUN;
                        remaining <= load_val;
                    end
                end
            endcase

            if (counted) begin
                o_retire_count    <= o_retire_count + OPTN_CNT_WIDTH'(1);
                hist_rdst[wr_ptr] <= i_retire_rdst;
                hist_data[wr_ptr] <= i_retire_data;
                wr_ptr            <= wr_ptr + HIST_IDX_WIDTH'(1);
                if (vcnt != (HIST_IDX_WIDTH+1)'(OPTN_HIST_DEPTH))
                    vcnt <= vcnt + (HIST_IDX_WIDTH+1)'(1);
                if (i_mode == MODE_COUNT)
                    remaining <= remaining - OPTN_CNT_WIDTH'(1);
            end

            if ({1'b0, i_hist_sel} < vcnt) begin
                o_hist_valid <= 1'b1;
                o_hist_rdst  <= hist_rdst[rd_idx];
                o_hist_data  <= hist_data[rd_idx];
            end else begin
                o_hist_valid <= 1'b0;
                o_hist_rdst  <= '0;
                o_hist_data  <= '0;
            end
        end
    end

endmodule

// File: tb/tb_procyon_debug_ctrl.sv
// Scoreboard bench for procyon_debug_ctrl: run/halt policy, counters and history readout.
module tb_procyon_debug_ctrl;

    logic        clk = 1'b0;
    logic        n_rst = 1'b1;
    logic [1:0]  i_mode = 2'd0;
    logic [15:0] i_step_count = 16'd1;
    logic        i_key_pulse = 1'b0;
    logic        i_retire_en = 1'b0;
    logic [4:0]  i_retire_rdst = '0;
    logic [31:0] i_retire_data = '0;
    logic        i_redirect = 1'b0;
    logic [31:0] i_redirect_addr = '0;
    logic [31:0] i_bp_addr = '0;
    logic [2:0]  i_hist_sel = '0;
    logic        o_clk_en, o_halted, o_hist_valid;
    logic [4:0]  o_hist_rdst;
    logic [31:0] o_hist_data;
    logic [15:0] o_retire_count;

    int checks = 0;
    int errors = 0;

    typedef struct {
        logic [4:0]  rdst;
        logic [31:0] data;
    } ent_t;
    typedef struct {
        int          sel;
        logic        valid;
        logic [4:0]  rdst;
        logic [31:0] data;
    } exp_t;

    ent_t hq[$];
    exp_t sb[$];
    bit   m_run;
    int   m_rem;
    int   m_cnt;

    procyon_debug_ctrl dut (
        .clk(clk), .n_rst(n_rst), .i_mode(i_mode),
        .i_step_count(i_step_count), .i_key_pulse(i_key_pulse),
        .i_retire_en(i_retire_en), .i_retire_rdst(i_retire_rdst),
        .i_retire_data(i_retire_data), .i_redirect(i_redirect),
        .i_redirect_addr(i_redirect_addr),
`ifdef PROCYON_DEBUG_BREAKPOINT_EN
        .i_bp_addr(i_bp_addr),
`endif
        .i_hist_sel(i_hist_sel), .o_clk_en(o_clk_en), .o_halted(o_halted),
        .o_hist_valid(o_hist_valid), .o_hist_rdst(o_hist_rdst),
        .o_hist_data(o_hist_data), .o_retire_count(o_retire_count)
    );

    always #5 clk = ~clk;

    function automatic int ld();
        return (i_step_count == 0) ? 1 : int'(i_step_count);
    endfunction

    // One clock with the given core inputs; the model tracks what the DUT should do.
    task automatic step(input bit en, input logic [4:0] rd, input logic [31:0] d,
                        input bit key, input bit redir, input logic [31:0] ra);
        bit cnt_r, bp, hreq;
        i_retire_en = en; i_retire_rdst = rd; i_retire_data = d;
        i_key_pulse = key; i_redirect = redir; i_redirect_addr = ra;
        cnt_r = en && m_run;
`ifdef PROCYON_DEBUG_BREAKPOINT_EN
        bp = (i_mode == 3) && redir && (ra == i_bp_addr);
`else
        bp = 0;
`endif
        hreq = key || (i_mode == 1 && cnt_r) || (i_mode == 2 && cnt_r && m_rem == 1) || bp;
        if (m_run) begin
            if (cnt_r) begin
                m_cnt++;
                hq.push_back('{rdst: rd, data: d});
                if (i_mode == 2) m_rem--;
            end
            if (hreq) m_run = 0;
        end else if (key) begin
            m_run = 1;
            m_rem = ld();
        end
        @(posedge clk); #1;
        i_retire_en = 0; i_key_pulse = 0; i_redirect = 0;
    endtask

    task automatic rd_push(input int s);
        exp_t e;
        int n, vn;
        n = hq.size();
        vn = (n > 8) ? 8 : n;
        e.sel = s;
        if (s < vn) begin
            e.valid = 1; e.rdst = hq[n-1-s].rdst; e.data = hq[n-1-s].data;
        end else begin
            e.valid = 0; e.rdst = '0; e.data = '0;
        end
        sb.push_back(e);
    endtask

    task automatic rd_pop();
        exp_t e;
        e = sb.pop_front();
        checks++;
        if (o_hist_valid !== e.valid || o_hist_rdst !== e.rdst || o_hist_data !== e.data) begin
            errors++;
            $display("FAIL hist_sel%0d: got v=%0b r=%0d d=%h, want v=%0b r=%0d d=%h",
                     e.sel, o_hist_valid, o_hist_rdst, o_hist_data, e.valid, e.rdst, e.data);
        end
    endtask

    task automatic rd_ret(input int s, input bit en, input logic [4:0] rd, input logic [31:0] d);
        i_hist_sel = 3'(s);
        rd_push(s);
        step(en, rd, d, 0, 0, '0);
        rd_pop();
    endtask

    task automatic do_reset();
        n_rst = 0;
        @(posedge clk); #1;
        n_rst = 1;
        hq.delete();
        m_run = 1; m_cnt = 0; m_rem = ld();
    endtask

    task automatic chk_halt(input string nm, input logic want);
        checks++;
        if (o_halted !== want || o_clk_en !== ~want) begin
            errors++;
            $display("FAIL %s: halted=%0b clk_en=%0b, want halted=%0b", nm, o_halted, o_clk_en, want);
        end
    endtask

    task automatic chk_cnt(input string nm, input int want);
        checks++;
        if (o_retire_count !== 16'(want)) begin
            errors++;
            $display("FAIL %s: count=%0d, want %0d", nm, o_retire_count, want);
        end
    endtask

    task automatic test_reset();
        i_mode = 0; i_hist_sel = 0;
        do_reset();
        checks++;
        if (o_clk_en !== 1'b1 || o_halted !== 1'b0 || o_retire_count !== 16'd0 ||
            o_hist_valid !== 1'b0 || o_hist_rdst !== 5'd0 || o_hist_data !== 32'd0) begin
            errors++;
            $display("FAIL reset: en=%0b h=%0b cnt=%0d v=%0b r=%0d d=%h, want 1 0 0 0 0 0",
                     o_clk_en, o_halted, o_retire_count, o_hist_valid, o_hist_rdst, o_hist_data);
        end
    endtask

    task automatic test_free();
        bit ok = 1;
        i_mode = 0;
        for (int i = 1; i <= 20; i++) begin
            step(1, 5'(i), 32'h1000 + i, 0, 0, '0);
            if (o_clk_en !== 1'b1) ok = 0;
        end
        checks++;
        if (!ok) begin
            errors++;
            $display("FAIL free_clk_en: dropped, want held 1");
        end
        chk_cnt("free_count", 20);
        rd_ret(0, 0, '0, '0);
        checks++;
        if (o_hist_data !== 32'h1014 || o_hist_rdst !== 5'd20) begin
            errors++;
            $display("FAIL free_newest: r=%0d d=%h, want r=20 d=00001014", o_hist_rdst, o_hist_data);
        end
    endtask

    task automatic test_step();
        i_mode = 1;
        do_reset();
        step(1, 5'd5, 32'hDEAD, 0, 0, '0);
        chk_halt("step_halt", 1);
        chk_cnt("step_cnt1", 1);
        for (int i = 0; i < 10; i++) step(1, 5'd6, 32'hBEEF, 0, 0, '0);
        chk_halt("step_held", 1);
        chk_cnt("step_ignored", 1);
        step(1, 5'd7, 32'hCAFE, 1, 0, '0);
        chk_halt("step_resume", 0);
        chk_cnt("step_resume_cnt", 1);
        step(1, 5'd8, 32'hF00D, 0, 0, '0);
        chk_halt("step_rehalt", 1);
        chk_cnt("step_cnt2", 2);
        rd_ret(0, 0, '0, '0);
        rd_ret(1, 0, '0, '0);
    endtask

    task automatic test_count();
        i_mode = 2; i_step_count = 3;
        do_reset();
        step(1, 5'd1, 32'h11, 0, 0, '0);
        chk_halt("count_r1", 0);
        step(1, 5'd2, 32'h22, 0, 0, '0);
        chk_halt("count_r2", 0);
        step(1, 5'd3, 32'h33, 0, 0, '0);
        chk_halt("count_r3", 1);
        step(1, 5'd4, 32'h44, 0, 0, '0);
        chk_cnt("count_3", 3);
        i_step_count = 0;
        step(0, '0, '0, 1, 0, '0);
        chk_halt("count_resume", 0);
        step(1, 5'd9, 32'h99, 0, 0, '0);
        chk_halt("count0_halt", 1);
        chk_cnt("count0_cnt", 4);
        i_step_count = 1;
    endtask

    task automatic test_history();
        i_mode = 0;
        do_reset();
        for (int i = 1; i <= 10; i++) step(1, 5'(i + 10), 32'hA00 + i, 0, 0, '0);
        for (int s = 0; s < 8; s++) rd_ret(s, 0, '0, '0);
        rd_ret(7, 1, 5'd30, 32'hB0B);
        rd_ret(0, 0, '0, '0);
        do_reset();
        step(1, 5'd1, 32'h1, 0, 0, '0);
        step(1, 5'd2, 32'h2, 0, 0, '0);
        rd_ret(2, 0, '0, '0);
        rd_ret(1, 0, '0, '0);
    endtask

    task automatic test_break();
        bit ok = 1;
        i_mode = 3; i_bp_addr = 32'h100;
        do_reset();
`ifdef PROCYON_DEBUG_BREAKPOINT_EN
        step(1, 5'd1, 32'h1, 0, 1, 32'h0FC);
        chk_halt("bp_near", 0);
        step(1, 5'd2, 32'h2, 0, 1, 32'h100);
        chk_halt("bp_hit", 1);
        chk_cnt("bp_cnt", 2);
`else
        for (int i = 0; i < 10; i++) begin
            step(1, 5'(i), 32'(i), 0, 1, (i % 2 == 0) ? 32'h100 : 32'h0FC);
            if (o_halted !== 1'b0) ok = 0;
        end
        checks++;
        if (!ok) begin
            errors++;
            $display("FAIL mode3_free: halted, want never");
        end
        chk_cnt("mode3_cnt", 10);
`endif
    endtask

    task automatic test_key_coincide();
        i_mode = 1;
        do_reset();
        step(1, 5'd3, 32'h3, 1, 0, '0);
        chk_halt("key_coincide", 1);
        step(0, '0, '0, 0, 0, '0);
        chk_halt("key_coincide_hold", 1);
    endtask

    task automatic test_reset_mid();
        i_mode = 0;
        do_reset();
        for (int i = 0; i < 5; i++) step(1, 5'd4, 32'h55, 0, 0, '0);
        i_hist_sel = 0;
        step(0, '0, '0, 0, 0, '0);
        do_reset();
        checks++;
        if (o_clk_en !== 1'b1 || o_retire_count !== 16'd0 || o_hist_valid !== 1'b0 ||
            o_hist_data !== 32'd0) begin
            errors++;
            $display("FAIL reset_run: en=%0b cnt=%0d v=%0b d=%h, want 1 0 0 0",
                     o_clk_en, o_retire_count, o_hist_valid, o_hist_data);
        end
        step(0, '0, '0, 1, 0, '0);
        chk_halt("pre_reset_halt", 1);
        do_reset();
        chk_halt("reset_halt", 0);
        rd_ret(0, 0, '0, '0);
    endtask

    initial begin
        #2;
        test_reset();
        test_free();
        test_step();
        test_count();
        test_history();
        test_break();
        test_key_coincide();
        test_reset_mid();
        $display("Simulation finished: %0d checks, %0d errors", checks, errors);
        $finish;
    end

endmodule
